// File: rtl/maze_pkg.sv
// Shared constants, state encoding and wall-map builders for the maze environment model.
package maze_pkg;

    localparam logic [2:0] MV_STOP    = 3'd0;
    localparam logic [2:0] MV_FORWARD = 3'd1;
    localparam logic [2:0] MV_LEFT    = 3'd2;
    localparam logic [2:0] MV_RIGHT   = 3'd3;
    localparam logic [2:0] MV_UTURN   = 3'd4;

    localparam logic [1:0] HDG_N = 2'd0;
    localparam logic [1:0] HDG_E = 2'd1;
    localparam logic [1:0] HDG_S = 2'd2;
    localparam logic [1:0] HDG_W = 2'd3;

    // Bit positions inside a cell's 4-bit wall nibble {W,S,E,N}; equal to the heading code.
    localparam int WALL_N = 0;
    localparam int WALL_E = 1;
    localparam int WALL_S = 2;
    localparam int WALL_W = 3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_EXITED,
        ST_CRASHED
    } env_state_t;

    function automatic int cell_index(input int x, input int y, input int cols);
        return y * cols + x;
    endfunction

    function automatic logic [323:0] build_open_9x9();
        logic [323:0] m;
        m = '0;
        for (int y = 0; y < 9; y++) begin
            for (int x = 0; x < 9; x++) begin
                if (y == 0) m[cell_index(x, y, 9)*4 + WALL_S] = 1'b1;
                if (y == 8) m[cell_index(x, y, 9)*4 + WALL_N] = 1'b1;
                if (x == 0) m[cell_index(x, y, 9)*4 + WALL_W] = 1'b1;
                if (x == 8) m[cell_index(x, y, 9)*4 + WALL_E] = 1'b1;
            end
        end
        return m;
    endfunction

    // Open map with cell (4,1) closed on N/E/W; neighbours get the matching wall faces.
    function automatic logic [323:0] build_deadend_9x9();
        logic [323:0] m;
        m = build_open_9x9();
        m[cell_index(4, 1, 9)*4 + WALL_N] = 1'b1;
        m[cell_index(4, 1, 9)*4 + WALL_E] = 1'b1;
        m[cell_index(4, 1, 9)*4 + WALL_W] = 1'b1;
        m[cell_index(4, 2, 9)*4 + WALL_S] = 1'b1;
        m[cell_index(5, 1, 9)*4 + WALL_W] = 1'b1;
        m[cell_index(3, 1, 9)*4 + WALL_E] = 1'b1;
        return m;
    endfunction

    localparam logic [323:0] MAZE_OPEN_9X9    = build_open_9x9();
    localparam logic [323:0] MAZE_DEADEND_9X9 = build_deadend_9x9();

endpackage

// File: rtl/maze_wall_lookup.sv
// Combinational wall fetch for one cell, rotated into the bot's left/mid/right frame.
module maze_wall_lookup
    import maze_pkg::*;
#(
    parameter int COLS = 9,
    parameter int ROWS = 9,
    parameter logic [4*ROWS*COLS-1:0] MAZE_WALLS = MAZE_OPEN_9X9
) (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [1:0] heading,
    output logic [3:0] walls,
    output logic       left,
    output logic       mid,
    output logic       right,
    output logic       dead_end
);

    logic [1:0] hdg_right;
    logic [1:0] hdg_left;

    always_comb begin
        walls = '0;
        // Off-grid coordinates read as an open cell; the caller rejects them separately.
        if (int'(x) < COLS && int'(y) < ROWS)
            walls = MAZE_WALLS[cell_index(int'(x), int'(y), COLS)*4 +: 4];
    end

    assign hdg_right = heading + 2'd1;
    assign hdg_left  = heading + 2'd3;

    assign mid      = walls[heading];
    assign right    = walls[hdg_right];
    assign left     = walls[hdg_left];
    assign dead_end = ($countones(walls) == 3);

endmodule

// File: rtl/maze_env_model.sv
// Maze environment: executes explorer move commands against a wall map and reports sensors/flags.
module maze_env_model
    import maze_pkg::*;
#(
    parameter int COLS      = 9,
    parameter int ROWS      = 9,
    parameter int START_X   = 4,
    parameter int START_Y   = 0,
    parameter int START_HDG = 0,
    parameter int EXIT_X    = 4,
    parameter int EXIT_Y    = 8,
    parameter logic [4*ROWS*COLS-1:0] MAZE_WALLS = MAZE_OPEN_9X9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  move,
    output logic        left,
    output logic        mid,
    output logic        right,
    output logic [3:0]  pos_x,
    output logic [3:0]  pos_y,
    output logic [1:0]  heading,
    output logic        at_exit,
    output logic        crashed,
    output logic        bad_cmd,
    output logic [15:0] step_count,
    output logic [7:0]  deadend_count
);

    env_state_t  state_q, state_d;
    logic [3:0]  x_q, x_d, y_q, y_d;
    logic [1:0]  hdg_q, hdg_d, new_hdg;
    logic        bad_q, bad_d;
    logic [15:0] steps_q, steps_d;
    logic [7:0]  dead_q, dead_d;
    logic [4:0]  tx, ty;
    logic        in_bounds;
    logic [3:0]  cur_walls, tgt_unused_walls;
    logic        cur_unused_de, tgt_dead, tgt_unused_l, tgt_unused_m, tgt_unused_r;

    maze_wall_lookup #(.COLS(COLS), .ROWS(ROWS), .MAZE_WALLS(MAZE_WALLS)) u_cur (
        .x(x_q), .y(y_q), .heading(hdg_q), .walls(cur_walls),
        .left(left), .mid(mid), .right(right), .dead_end(cur_unused_de)
    );

    maze_wall_lookup #(.COLS(COLS), .ROWS(ROWS), .MAZE_WALLS(MAZE_WALLS)) u_tgt (
        .x(tx[3:0]), .y(ty[3:0]), .heading(new_hdg), .walls(tgt_unused_walls),
        .left(tgt_unused_l), .mid(tgt_unused_m), .right(tgt_unused_r), .dead_end(tgt_dead)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            x_q     <= 4'(START_X);
            y_q     <= 4'(START_Y);
            hdg_q   <= 2'(START_HDG);
            bad_q   <= 1'b0;
            steps_q <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hdg_q   <= hdg_d;
            bad_q   <= bad_d;
            steps_q <= steps_d;
            dead_q  <= dead_d;
        end
    end

    always_comb begin
        new_hdg = hdg_q;
        case (move)
            MV_LEFT:  new_hdg = hdg_q - 2'd1;
            MV_RIGHT: new_hdg = hdg_q + 2'd1;
            MV_UTURN: new_hdg = hdg_q + 2'd2;
            default:  new_hdg = hdg_q;
        endcase
        // 5-bit intermediates so stepping off either edge is seen as out of range, not wrapped.
        tx = {1'b0, x_q};
        ty = {1'b0, y_q};
        case (new_hdg)
            HDG_N:   ty = ty + 5'd1;
            HDG_E:   tx = tx + 5'd1;
            HDG_S:   ty = ty - 5'd1;
            default: tx = tx - 5'd1;
        endcase
        in_bounds = !tx[4] && !ty[4] && (tx < 5'(COLS)) && (ty < 5'(ROWS));
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hdg_d   = hdg_q;
        bad_d   = bad_q;
        steps_d = steps_q;
        dead_d  = dead_q;
        case (state_q)
            ST_RUN: begin
                if (x_q == 4'(EXIT_X) && y_q == 4'(EXIT_Y)) begin
                    state_d = ST_EXITED;
                end else if (move > MV_UTURN) begin
                    bad_d = 1'b1;
                end else if (move != MV_STOP) begin
                    if (cur_walls[new_hdg] || !in_bounds) begin
                        state_d = ST_CRASHED;
                    end else begin
                        x_d   = tx[3:0];
                        y_d   = ty[3:0];
                        hdg_d = new_hdg;
                        if (steps_q != 16'hFFFF) steps_d = steps_q + 16'd1;
                        if (tgt_dead && dead_q != 8'hFF) dead_d = dead_q + 8'd1;
                        if (tx[3:0] == 4'(EXIT_X) && ty[3:0] == 4'(EXIT_Y)) state_d = ST_EXITED;
                    end
                end
            end
            default: ;
        endcase
    end

    assign pos_x         = x_q;
    assign pos_y         = y_q;
    assign heading       = hdg_q;
    assign at_exit       = (state_q == ST_EXITED);
    assign crashed       = (state_q == ST_CRASHED);
    assign bad_cmd       = bad_q;
    assign step_count    = steps_q;
    assign deadend_count = dead_q;

endmodule

// File: tb/tb_maze_env_model.sv
// Bench for maze_env_model: open-map and dead-end-map instances checked against a grid-walk model.
module tb_maze_env_model;
    import maze_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  mv_in [2];
    logic        s_l [2], s_m [2], s_r [2], ax [2], cr [2], bc [2];
    logic [3:0]  px [2], py [2];
    logic [1:0]  hd [2];
    logic [15:0] sc [2];
    logic [7:0]  dc [2];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance (0 = open map, 1 = dead-end map).
    int mx [2], my [2], mh [2], mst [2], mbad [2], msteps [2], mdead [2];
    bit mw [2][9][9][4];
    int turn [5] = '{0, 0, 3, 1, 2};
    int ddx  [4] = '{0, 1, 0, -1};
    int ddy  [4] = '{1, 0, -1, 0};

    always #5 clk = ~clk;

    maze_env_model u_open (
        .clk(clk), .rst_n(rst_n), .move(mv_in[0]),
        .left(s_l[0]), .mid(s_m[0]), .right(s_r[0]),
        .pos_x(px[0]), .pos_y(py[0]), .heading(hd[0]),
        .at_exit(ax[0]), .crashed(cr[0]), .bad_cmd(bc[0]),
        .step_count(sc[0]), .deadend_count(dc[0])
    );

    maze_env_model #(.MAZE_WALLS(MAZE_DEADEND_9X9)) u_dead (
        .clk(clk), .rst_n(rst_n), .move(mv_in[1]),
        .left(s_l[1]), .mid(s_m[1]), .right(s_r[1]),
        .pos_x(px[1]), .pos_y(py[1]), .heading(hd[1]),
        .at_exit(ax[1]), .crashed(cr[1]), .bad_cmd(bc[1]),
        .step_count(sc[1]), .deadend_count(dc[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mx[c] = 4; my[c] = 0; mh[c] = 0; mst[c] = 0;
            mbad[c] = 0; msteps[c] = 0; mdead[c] = 0;
        end
    endtask

    task automatic model_step(input int c, input int mv);
        int nh, tx, ty, n;
        if (mst[c] != 0) return;
        if (mx[c] == 4 && my[c] == 8) begin mst[c] = 1; return; end
        if (mv > 4) begin mbad[c] = 1; return; end
        if (mv == 0) return;
        nh = (mh[c] + turn[mv]) % 4;
        tx = mx[c] + ddx[nh];
        ty = my[c] + ddy[nh];
        if (mw[c][mx[c]][my[c]][nh] || tx < 0 || tx > 8 || ty < 0 || ty > 8) begin
            mst[c] = 2;
            return;
        end
        mx[c] = tx; my[c] = ty; mh[c] = nh;
        if (msteps[c] < 65535) msteps[c]++;
        n = 0;
        for (int d = 0; d < 4; d++) n += int'(mw[c][tx][ty][d]);
        if (n == 3 && mdead[c] < 255) mdead[c]++;
        if (tx == 4 && ty == 8) mst[c] = 1;
    endtask

    task automatic check_all(input int c, input string tag);
        chk({tag, ".pos_x"},   32'(px[c]), 32'(mx[c]));
        chk({tag, ".pos_y"},   32'(py[c]), 32'(my[c]));
        chk({tag, ".heading"}, 32'(hd[c]), 32'(mh[c]));
        chk({tag, ".mid"},     32'(s_m[c]), 32'(mw[c][mx[c]][my[c]][mh[c]]));
        chk({tag, ".right"},   32'(s_r[c]), 32'(mw[c][mx[c]][my[c]][(mh[c] + 1) % 4]));
        chk({tag, ".left"},    32'(s_l[c]), 32'(mw[c][mx[c]][my[c]][(mh[c] + 3) % 4]));
        chk({tag, ".at_exit"}, 32'(ax[c]), 32'(mst[c] == 1));
        chk({tag, ".crashed"}, 32'(cr[c]), 32'(mst[c] == 2));
        chk({tag, ".bad_cmd"}, 32'(bc[c]), 32'(mbad[c]));
        chk({tag, ".steps"},   32'(sc[c]), 32'(msteps[c]));
        chk({tag, ".deadend"}, 32'(dc[c]), 32'(mdead[c]));
    endtask

    task automatic reset_all(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        mv_in[0] = 3'd0;
        mv_in[1] = 3'd0;
        @(posedge clk);
        #1;
        model_reset();
        check_all(0, tag);
        check_all(1, tag);
        rst_n = 1'b1;
    endtask

    task automatic apply(input int c, input int mv, input string tag);
        @(negedge clk);
        mv_in[c]     = mv[2:0];
        mv_in[1 - c] = 3'd0;
        @(posedge clk);
        #1;
        model_step(c, mv);
        check_all(c, tag);
    endtask

    initial begin
        int mv, c;
        mv_in[0] = 3'd0;
        mv_in[1] = 3'd0;
        for (int k = 0; k < 2; k++)
            for (int x = 0; x < 9; x++)
                for (int y = 0; y < 9; y++) begin
                    mw[k][x][y][0] = (y == 8);
                    mw[k][x][y][1] = (x == 8);
                    mw[k][x][y][2] = (y == 0);
                    mw[k][x][y][3] = (x == 0);
                end
        mw[1][4][1][0] = 1; mw[1][4][1][1] = 1; mw[1][4][1][3] = 1;
        mw[1][4][2][2] = 1; mw[1][5][1][3] = 1; mw[1][3][1][1] = 1;
        model_reset();

        reset_all("rst");
        chk("rst.x_const", 32'(px[0]), 32'd4);
        chk("rst.mid_const", 32'(s_m[0]), 32'd0);

        for (int i = 0; i < 8; i++) apply(0, 1, "fwd");
        chk("fwd.exit_const", 32'(ax[0]), 32'd1);
        chk("fwd.y_const", 32'(py[0]), 32'd8);
        apply(0, 3, "exited_ignore");
        apply(0, 3, "exited_ignore");
        chk("exited.steps_const", 32'(sc[0]), 32'd8);

        reset_all("rst2");
        apply(0, 3, "right_turn");
        chk("right_turn.right_const", 32'(s_r[0]), 32'd1);
        apply(0, 2, "left_turn");
        chk("left_turn.x_const", 32'(px[0]), 32'd5);

        reset_all("rst3");
        apply(0, 4, "uturn_crash");
        chk("uturn.crash_const", 32'(cr[0]), 32'd1);
        apply(0, 1, "crash_ignore");

        reset_all("rst4");
        apply(0, 6, "illegal");
        apply(0, 1, "after_illegal");
        chk("after_illegal.y_const", 32'(py[0]), 32'd1);

        reset_all("rst5");
        apply(1, 1, "deadend");
        chk("deadend.count_const", 32'(dc[1]), 32'd1);
        chk("deadend.left_const", 32'(s_l[1]), 32'd1);
        apply(1, 1, "deadend_crash");
        reset_all("rst_mid");
        chk("rst_mid.crash_const", 32'(cr[1]), 32'd0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                reset_all("rand_rst");
            end else begin
                c  = int'($urandom_range(0, 1));
                mv = ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(0, 7));
                apply(c, mv, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
